// File: rtl/ltssm_timer_pkg.sv
// Shared LTSSM timer duration codes and code-to-millisecond decode.
`timescale 1ns/1ps
package ltssm_timer_pkg;

    localparam logic [2:0] t0ms  = 3'd0;
    localparam logic [2:0] t12ms = 3'd1;
    localparam logic [2:0] t24ms = 3'd2;
    localparam logic [2:0] t48ms = 3'd3;
    localparam logic [2:0] t2ms  = 3'd4;
    localparam logic [2:0] t8ms  = 3'd5;
    localparam logic [2:0] t1ms  = 3'd6;

    function automatic logic [5:0] decode_ms(input logic [2:0] code);
        logic [5:0] ms;
        ms = 6'd0;
        case (code)
            t12ms:   ms = 6'd12;
            t24ms:   ms = 6'd24;
            t48ms:   ms = 6'd48;
            t2ms:    ms = 6'd2;
            t8ms:    ms = 6'd8;
            t1ms:    ms = 6'd1;
            default: ms = 6'd0;
        endcase
        return ms;
    endfunction

endpackage

// File: rtl/ltssm_rx_timer_ms_tick_gen.sv
// Millisecond prescaler: tick_o marks the edge on which the prescaler wraps.
`timescale 1ns/1ps
module ms_tick_gen #(
    parameter int CYCLES_PER_MS = 250000,
    parameter int PRESC_W       = 18
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic run_i,
    output logic tick_o
);

    localparam logic [PRESC_W-1:0] LAST = PRESC_W'(CYCLES_PER_MS - 1);

    logic [PRESC_W-1:0] presc_q;
    logic [PRESC_W-1:0] presc_d;
    logic               wrap;

    assign wrap   = run_i && (presc_q == LAST);
    assign tick_o = wrap;

    always_comb begin
        presc_d = presc_q;
        if (clear_i) begin
            presc_d = '0;
        end else if (wrap) begin
            presc_d = '0;
        end else if (run_i) begin
            presc_d = presc_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

endmodule

// File: rtl/ltssm_rx_timer.sv
// Receive-side LTSSM timeout timer: latches a duration code and raises a
// sticky timeOut after that many milliseconds of enabled counting.
`timescale 1ns/1ps
module ltssm_rx_timer
    import ltssm_timer_pkg::*;
#(
    parameter int CYCLES_PER_MS = 250000,
    parameter int PRESC_W       = 18
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] timeToWait,
    input  logic       startTimer,
    input  logic       enableTimer,
    input  logic       resetTimer,
    output logic       timeOut,
    output logic       timerRunning,
    output logic [5:0] elapsedMs
);

    logic [5:0] target_q;
    logic [5:0] elapsed_q;
    logic       timeout_q;
    logic       running_q;

    logic [5:0] new_target;
    logic [5:0] elapsed_inc;
    logic       presc_clear;
    logic       presc_run;
    logic       ms_tick;

    assign new_target  = decode_ms(timeToWait);
    assign elapsed_inc = elapsed_q + 6'd1;
    assign presc_clear = startTimer || !resetTimer;
    assign presc_run   = !presc_clear && enableTimer && running_q;

    ms_tick_gen #(
        .CYCLES_PER_MS (CYCLES_PER_MS),
        .PRESC_W       (PRESC_W)
    ) u_tick (
        .clk     (clk),
        .rst_n   (reset),
        .clear_i (presc_clear),
        .run_i   (presc_run),
        .tick_o  (ms_tick)
    );

    // Start beats clear beats counting; anything else holds.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            target_q  <= '0;
            elapsed_q <= '0;
            timeout_q <= 1'b0;
            running_q <= 1'b0;
        end else if (startTimer) begin
            target_q  <= new_target;
            elapsed_q <= '0;
            timeout_q <= (new_target == 6'd0);
            running_q <= (new_target != 6'd0);
        end else if (!resetTimer) begin
            elapsed_q <= '0;
            timeout_q <= 1'b0;
            running_q <= 1'b0;
        end else if (presc_run && ms_tick) begin
            elapsed_q <= elapsed_inc;
            if (elapsed_inc == target_q) begin
                timeout_q <= 1'b1;
                running_q <= 1'b0;
            end
        end
    end

    assign timeOut      = timeout_q;
    assign timerRunning = running_q;
    assign elapsedMs    = elapsed_q;

endmodule

// File: tb/tb_ltssm_rx_timer.sv
// Directed testbench for ltssm_rx_timer with a 10-cycle millisecond.
`timescale 1ns/1ps
module tb_ltssm_rx_timer;

    logic       clk;
    logic       reset;
    logic [2:0] timeToWait;
    logic       startTimer;
    logic       enableTimer;
    logic       resetTimer;
    logic       timeOut;
    logic       timerRunning;
    logic [5:0] elapsedMs;

    int errors = 0;
    int checks = 0;

    ltssm_rx_timer #(
        .CYCLES_PER_MS (10),
        .PRESC_W       (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .timeToWait   (timeToWait),
        .startTimer   (startTimer),
        .enableTimer  (enableTimer),
        .resetTimer   (resetTimer),
        .timeOut      (timeOut),
        .timerRunning (timerRunning),
        .elapsedMs    (elapsedMs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_pulse(input logic [2:0] code);
        timeToWait = code;
        startTimer = 1'b1;
        step(1);
        startTimer = 1'b0;
    endtask

    task automatic test_reset;
        checks++;
        if ({timeOut, timerRunning, elapsedMs} !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: got to=%b run=%b ms=%0d want 0 0 0",
                     timeOut, timerRunning, elapsedMs);
        end
    endtask

    task automatic test_basic;
        start_pulse(3'd6);
        checks++;
        if (timerRunning !== 1'b1 || timeOut !== 1'b0) begin
            errors++;
            $display("FAIL basic_start: got to=%b run=%b want 0 1",
                     timeOut, timerRunning);
        end
        step(9);
        checks++;
        if (timeOut !== 1'b0 || elapsedMs !== 6'd0) begin
            errors++;
            $display("FAIL basic_edge9: got to=%b ms=%0d want 0 0",
                     timeOut, elapsedMs);
        end
        step(1);
        checks++;
        if (timeOut !== 1'b1 || timerRunning !== 1'b0 || elapsedMs !== 6'd1) begin
            errors++;
            $display("FAIL basic_edge10: got to=%b run=%b ms=%0d want 1 0 1",
                     timeOut, timerRunning, elapsedMs);
        end
        enableTimer = 1'b0;
        step(25);
        enableTimer = 1'b1;
        step(25);
        checks++;
        if (timeOut !== 1'b1 || elapsedMs !== 6'd1 || timerRunning !== 1'b0) begin
            errors++;
            $display("FAIL sticky: got to=%b run=%b ms=%0d want 1 0 1",
                     timeOut, timerRunning, elapsedMs);
        end
        resetTimer = 1'b0;
        step(1);
        resetTimer = 1'b1;
        checks++;
        if (timeOut !== 1'b0 || elapsedMs !== 6'd0) begin
            errors++;
            $display("FAIL sticky_clear: got to=%b ms=%0d want 0 0",
                     timeOut, elapsedMs);
        end
    endtask

    task automatic test_pause;
        start_pulse(3'd6);
        step(3);
        enableTimer = 1'b0;
        step(5);
        enableTimer = 1'b1;
        checks++;
        if (elapsedMs !== 6'd0 || timerRunning !== 1'b1 || timeOut !== 1'b0) begin
            errors++;
            $display("FAIL pause_hold: got to=%b run=%b ms=%0d want 0 1 0",
                     timeOut, timerRunning, elapsedMs);
        end
        step(6);
        checks++;
        if (timeOut !== 1'b0) begin
            errors++;
            $display("FAIL pause_edge14: got to=%b want 0", timeOut);
        end
        step(1);
        checks++;
        if (timeOut !== 1'b1 || elapsedMs !== 6'd1) begin
            errors++;
            $display("FAIL pause_edge15: got to=%b ms=%0d want 1 1",
                     timeOut, elapsedMs);
        end
    endtask

    task automatic test_zero_codes;
        start_pulse(3'd0);
        checks++;
        if (timeOut !== 1'b1 || timerRunning !== 1'b0 || elapsedMs !== 6'd0) begin
            errors++;
            $display("FAIL code0: got to=%b run=%b ms=%0d want 1 0 0",
                     timeOut, timerRunning, elapsedMs);
        end
        resetTimer = 1'b0;
        step(1);
        resetTimer = 1'b1;
        start_pulse(3'd7);
        checks++;
        if (timeOut !== 1'b1 || timerRunning !== 1'b0 || elapsedMs !== 6'd0) begin
            errors++;
            $display("FAIL code7: got to=%b run=%b ms=%0d want 1 0 0",
                     timeOut, timerRunning, elapsedMs);
        end
    endtask

    task automatic test_restart;
        start_pulse(3'd3);
        step(199);
        checks++;
        if (elapsedMs !== 6'd19 || timerRunning !== 1'b1) begin
            errors++;
            $display("FAIL restart_pre: got run=%b ms=%0d want 1 19",
                     timerRunning, elapsedMs);
        end
        start_pulse(3'd6);
        checks++;
        if (elapsedMs !== 6'd0 || timerRunning !== 1'b1 || timeOut !== 1'b0) begin
            errors++;
            $display("FAIL restart_edge200: got to=%b run=%b ms=%0d want 0 1 0",
                     timeOut, timerRunning, elapsedMs);
        end
        step(9);
        checks++;
        if (timeOut !== 1'b0) begin
            errors++;
            $display("FAIL restart_edge209: got to=%b want 0", timeOut);
        end
        step(1);
        checks++;
        if (timeOut !== 1'b1 || elapsedMs !== 6'd1) begin
            errors++;
            $display("FAIL restart_edge210: got to=%b ms=%0d want 1 1",
                     timeOut, elapsedMs);
        end
    endtask

    task automatic test_clear;
        start_pulse(3'd4);
        step(14);
        checks++;
        if (elapsedMs !== 6'd1) begin
            errors++;
            $display("FAIL clear_pre: got ms=%0d want 1", elapsedMs);
        end
        resetTimer = 1'b0;
        step(1);
        resetTimer = 1'b1;
        checks++;
        if ({timeOut, timerRunning, elapsedMs} !== 8'h00) begin
            errors++;
            $display("FAIL clear_edge15: got to=%b run=%b ms=%0d want 0 0 0",
                     timeOut, timerRunning, elapsedMs);
        end
        step(40);
        checks++;
        if ({timeOut, timerRunning, elapsedMs} !== 8'h00) begin
            errors++;
            $display("FAIL clear_after: got to=%b run=%b ms=%0d want 0 0 0",
                     timeOut, timerRunning, elapsedMs);
        end
        resetTimer = 1'b0;
        start_pulse(3'd4);
        resetTimer = 1'b1;
        step(19);
        checks++;
        if (timeOut !== 1'b0 || elapsedMs !== 6'd1 || timerRunning !== 1'b1) begin
            errors++;
            $display("FAIL startwins_edge19: got to=%b run=%b ms=%0d want 0 1 1",
                     timeOut, timerRunning, elapsedMs);
        end
        step(1);
        checks++;
        if (timeOut !== 1'b1 || elapsedMs !== 6'd2) begin
            errors++;
            $display("FAIL startwins_edge20: got to=%b ms=%0d want 1 2",
                     timeOut, elapsedMs);
        end
    endtask

    task automatic test_async_reset;
        start_pulse(3'd1);
        step(56);
        checks++;
        if (elapsedMs !== 6'd5 || timerRunning !== 1'b1) begin
            errors++;
            $display("FAIL areset_pre: got run=%b ms=%0d want 1 5",
                     timerRunning, elapsedMs);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({timeOut, timerRunning, elapsedMs} !== 8'h00) begin
            errors++;
            $display("FAIL areset_now: got to=%b run=%b ms=%0d want 0 0 0",
                     timeOut, timerRunning, elapsedMs);
        end
        @(negedge clk);
        reset = 1'b1;
        step(150);
        checks++;
        if ({timeOut, timerRunning, elapsedMs} !== 8'h00) begin
            errors++;
            $display("FAIL areset_after: got to=%b run=%b ms=%0d want 0 0 0",
                     timeOut, timerRunning, elapsedMs);
        end
    endtask

    initial begin
        reset       = 1'b0;
        timeToWait  = 3'd0;
        startTimer  = 1'b0;
        enableTimer = 1'b1;
        resetTimer  = 1'b1;
        #2;
        test_reset();
        #20;
        reset = 1'b1;
        step(2);
        test_basic();
        test_pause();
        test_zero_codes();
        test_restart();
        test_clear();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
